// File: rtl/xif_arb_pkg.sv
// Shared types and helpers for the coprocessor XIF arbiter.
package xif_arb_pkg;

    // Widest owner field needed for up to 8 coprocessors.
    localparam int unsigned OWNER_MAX_W = 3;

    // One scoreboard entry per instruction ID.
    typedef struct packed {
        logic                   valid;
        logic [OWNER_MAX_W-1:0] owner;
        logic                   wb;
    } sb_entry_t;

    // Bits needed to name one of num_coproc coprocessors (at least 1).
    function automatic int unsigned owner_width(input int unsigned num_coproc);
        return (num_coproc > 1) ? $clog2(num_coproc) : 1;
    endfunction

endpackage

// File: rtl/xif_coproc_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer to grant+1. Grants only while en is high.
module xif_rr_arbiter
    import xif_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N-1:0]                  req,
    input  logic                          en,
    output logic [N-1:0]                  gnt,
    output logic [owner_width(N)-1:0]     gnt_idx
);

    localparam int unsigned IDX_W = owner_width(N);
    localparam int          NI    = int'(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     gnt_raw;
    logic             found;
    int               idx;

    // Cyclic search for the first requester starting at the pointer.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_raw = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NI; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NI) begin
                idx = idx - NI;
            end
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt_raw[idx] = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    assign gnt = en ? gnt_raw : '0;

    // Pointer moves past the winner only when a grant is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xif_coproc_arbiter.sv
// Shares one CORE-V-XIF port between NUM_COPROC coprocessors: broadcasts
// issue/commit, tracks the owner of each instruction ID in a scoreboard and
// round-robins the result channels into one registered CPU result channel.
module xif_coproc_arbiter
    import xif_arb_pkg::*;
#(
    parameter int unsigned NUM_COPROC = 2,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cpu_issue_valid_i,
    input  logic [ID_W-1:0]                cpu_issue_id_i,
    output logic                           cpu_issue_ready_o,
    output logic                           cpu_issue_accept_o,
    output logic                           cpu_issue_writeback_o,
    output logic [NUM_COPROC-1:0]          cp_issue_valid_o,
    input  logic [NUM_COPROC-1:0]          cp_issue_ready_i,
    input  logic [NUM_COPROC-1:0]          cp_issue_accept_i,
    input  logic [NUM_COPROC-1:0]          cp_issue_writeback_i,
    input  logic                           cpu_commit_valid_i,
    input  logic [ID_W-1:0]                cpu_commit_id_i,
    input  logic                           cpu_commit_kill_i,
    output logic [NUM_COPROC-1:0]          cp_commit_valid_o,
    input  logic [NUM_COPROC-1:0]          cp_result_valid_i,
    output logic [NUM_COPROC-1:0]          cp_result_ready_o,
    input  logic [NUM_COPROC*ID_W-1:0]     cp_result_id_i,
    input  logic [NUM_COPROC*DATA_W-1:0]   cp_result_data_i,
    input  logic [NUM_COPROC*5-1:0]        cp_result_rd_i,
    input  logic [NUM_COPROC-1:0]          cp_result_we_i,
    output logic                           cpu_result_valid_o,
    input  logic                           cpu_result_ready_i,
    output logic [ID_W-1:0]                cpu_result_id_o,
    output logic [DATA_W-1:0]              cpu_result_data_o,
    output logic [4:0]                     cpu_result_rd_o,
    output logic                           cpu_result_we_o,
    output logic                           busy_o,
    output logic                           error_o
);

    localparam int unsigned IDX_W = owner_width(NUM_COPROC);
    localparam int unsigned DEPTH = 2 ** ID_W;

    sb_entry_t sb_q [DEPTH];

    logic              blocked;
    logic [IDX_W-1:0]  winner;
    logic              multi_accept;
    logic              issue_hs;
    logic              issue_wr;
    logic              kill;

    logic              arb_en;
    logic [NUM_COPROC-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              res_hs;
    logic              res_ok;
    logic              res_good;
    logic              res_bad;
    logic [ID_W-1:0]   sel_id;
    logic [DATA_W-1:0] sel_data;
    logic [4:0]        sel_rd;
    logic              sel_we;

    logic              out_valid_q;
    logic [ID_W-1:0]   out_id_q;
    logic [DATA_W-1:0] out_data_q;
    logic [4:0]        out_rd_q;
    logic              out_we_q;
    logic              error_q;

    // ---------------- issue / commit (combinational) ----------------
    // An ID already in flight cannot be offered again until it retires.
    assign blocked            = sb_q[cpu_issue_id_i].valid;
    assign cp_issue_valid_o   = {NUM_COPROC{cpu_issue_valid_i & ~blocked}};
    assign cpu_issue_ready_o  = ~blocked & (&cp_issue_ready_i);
    assign cpu_issue_accept_o = |cp_issue_accept_i;
    assign multi_accept       = |(cp_issue_accept_i & (cp_issue_accept_i - 1'b1));

    // Lowest-index accepting coprocessor wins.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_COPROC) - 1; i >= 0; i--) begin
            if (cp_issue_accept_i[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    // Without any accept there is no winner, so no writeback is reported.
    assign cpu_issue_writeback_o = cpu_issue_accept_o & cp_issue_writeback_i[winner];
    assign issue_hs              = cpu_issue_valid_i & cpu_issue_ready_o;
    assign issue_wr              = issue_hs & cpu_issue_accept_o;

    assign cp_commit_valid_o = {NUM_COPROC{cpu_commit_valid_i}};
    assign kill              = cpu_commit_valid_i & cpu_commit_kill_i & sb_q[cpu_commit_id_i].valid;

    // ---------------- result channel ----------------
    // Grant only when the output register is empty or drains this cycle.
    assign arb_en = ~out_valid_q | cpu_result_ready_i;

    xif_rr_arbiter #(
        .N (NUM_COPROC)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (cp_result_valid_i),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign cp_result_ready_o = gnt;
    assign res_hs            = |gnt;

    // Payload of the granted coprocessor (gnt is one-hot).
    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        sel_rd   = '0;
        sel_we   = 1'b0;
        for (int i = 0; i < int'(NUM_COPROC); i++) begin
            if (gnt[i]) begin
                sel_id   = cp_result_id_i[i*ID_W +: ID_W];
                sel_data = cp_result_data_i[i*DATA_W +: DATA_W];
                sel_rd   = cp_result_rd_i[i*5 +: 5];
                sel_we   = cp_result_we_i[i];
            end
        end
    end

    // A result is only legitimate from the recorded owner of a live ID.
    assign res_ok   = sb_q[sel_id].valid && (sb_q[sel_id].owner == OWNER_MAX_W'(gnt_idx));
    assign res_good = res_hs & res_ok;
    assign res_bad  = res_hs & ~res_ok;

    // Scoreboard: clears from kill and result, set from accepted issue.
    // Issued IDs are never valid, so the set never collides with a clear.
    // NOTE: the scoreboard is reset entry by entry because an in-flight ID must never survive a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            if (kill) begin
                sb_q[cpu_commit_id_i].valid <= 1'b0;
            end
            if (res_good) begin
                sb_q[sel_id].valid <= 1'b0;
            end
            if (issue_wr) begin
                sb_q[cpu_issue_id_i] <= '{valid: 1'b1,
                                          owner: OWNER_MAX_W'(winner),
                                          wb:    cpu_issue_writeback_o};
            end
        end
    end

    // Output register: load on a good capture, otherwise drain on ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
        end else if (res_good) begin
            out_valid_q <= 1'b1;
            out_id_q    <= sel_id;
            out_data_q  <= sel_data;
            out_rd_q    <= sel_rd;
            out_we_q    <= sel_we;
        end else if (cpu_result_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky protocol error: multiple accepts or a stray result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
        end else if ((issue_hs & multi_accept) | res_bad) begin
            error_q <= 1'b1;
        end
    end

    // Busy while any scoreboard entry is live.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            busy_o = busy_o | sb_q[i].valid;
        end
    end

    assign cpu_result_valid_o = out_valid_q;
    assign cpu_result_id_o    = out_id_q;
    assign cpu_result_data_o  = out_data_q;
    assign cpu_result_rd_o    = out_rd_q;
    assign cpu_result_we_o    = out_we_q;
    assign error_o            = error_q;

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Self-checking bench for xif_coproc_arbiter: vector table for the issue and
// commit paths, hand sequences for result timing, random run against a model.
module tb_xif_coproc_arbiter;

    localparam int NC = 2;
    localparam int IW = 4;
    localparam int DW = 32;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                cpu_issue_valid_i;
    logic [IW-1:0]       cpu_issue_id_i;
    logic                cpu_issue_ready_o;
    logic                cpu_issue_accept_o;
    logic                cpu_issue_writeback_o;
    logic [NC-1:0]       cp_issue_valid_o;
    logic [NC-1:0]       cp_issue_ready_i;
    logic [NC-1:0]       cp_issue_accept_i;
    logic [NC-1:0]       cp_issue_writeback_i;
    logic                cpu_commit_valid_i;
    logic [IW-1:0]       cpu_commit_id_i;
    logic                cpu_commit_kill_i;
    logic [NC-1:0]       cp_commit_valid_o;
    logic [NC-1:0]       cp_result_valid_i;
    logic [NC-1:0]       cp_result_ready_o;
    logic [NC*IW-1:0]    cp_result_id_i;
    logic [NC*DW-1:0]    cp_result_data_i;
    logic [NC*5-1:0]     cp_result_rd_i;
    logic [NC-1:0]       cp_result_we_i;
    logic                cpu_result_valid_o;
    logic                cpu_result_ready_i;
    logic [IW-1:0]       cpu_result_id_o;
    logic [DW-1:0]       cpu_result_data_o;
    logic [4:0]          cpu_result_rd_o;
    logic                cpu_result_we_o;
    logic                busy_o;
    logic                error_o;

    always #5 clk_i = ~clk_i;

    xif_coproc_arbiter #(
        .NUM_COPROC (NC),
        .ID_W       (IW),
        .DATA_W     (DW)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .cpu_issue_valid_i     (cpu_issue_valid_i),
        .cpu_issue_id_i        (cpu_issue_id_i),
        .cpu_issue_ready_o     (cpu_issue_ready_o),
        .cpu_issue_accept_o    (cpu_issue_accept_o),
        .cpu_issue_writeback_o (cpu_issue_writeback_o),
        .cp_issue_valid_o      (cp_issue_valid_o),
        .cp_issue_ready_i      (cp_issue_ready_i),
        .cp_issue_accept_i     (cp_issue_accept_i),
        .cp_issue_writeback_i  (cp_issue_writeback_i),
        .cpu_commit_valid_i    (cpu_commit_valid_i),
        .cpu_commit_id_i       (cpu_commit_id_i),
        .cpu_commit_kill_i     (cpu_commit_kill_i),
        .cp_commit_valid_o     (cp_commit_valid_o),
        .cp_result_valid_i     (cp_result_valid_i),
        .cp_result_ready_o     (cp_result_ready_o),
        .cp_result_id_i        (cp_result_id_i),
        .cp_result_data_i      (cp_result_data_i),
        .cp_result_rd_i        (cp_result_rd_i),
        .cp_result_we_i        (cp_result_we_i),
        .cpu_result_valid_o    (cpu_result_valid_o),
        .cpu_result_ready_i    (cpu_result_ready_i),
        .cpu_result_id_o       (cpu_result_id_o),
        .cpu_result_data_o     (cpu_result_data_o),
        .cpu_result_rd_o       (cpu_result_rd_o),
        .cpu_result_we_o       (cpu_result_we_o),
        .busy_o                (busy_o),
        .error_o               (error_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        cpu_issue_valid_i    = 1'b0;
        cpu_issue_id_i       = '0;
        cp_issue_ready_i     = '1;
        cp_issue_accept_i    = '0;
        cp_issue_writeback_i = '0;
        cpu_commit_valid_i   = 1'b0;
        cpu_commit_id_i      = '0;
        cpu_commit_kill_i    = 1'b0;
        cp_result_valid_i    = '0;
        cp_result_id_i       = '0;
        cp_result_data_i     = '0;
        cp_result_rd_i       = '0;
        cp_result_we_i       = '0;
        cpu_result_ready_i   = 1'b0;
    endtask

    // Inputs are driven 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_res(input int cp, input logic [IW-1:0] id, input logic [DW-1:0] data,
                           input logic [4:0] rd, input logic we);
        cp_result_valid_i[cp]          = 1'b1;
        cp_result_id_i[cp*IW +: IW]    = id;
        cp_result_data_i[cp*DW +: DW]  = data;
        cp_result_rd_i[cp*5 +: 5]      = rd;
        cp_result_we_i[cp]             = we;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_res_valid", cpu_result_valid_o, 0);
        check("rst_res_id",    cpu_result_id_o, 0);
        check("rst_res_data",  cpu_result_data_o, 0);
        check("rst_res_rd",    cpu_result_rd_o, 0);
        check("rst_res_we",    cpu_result_we_o, 0);
        check("rst_busy",      busy_o, 0);
        check("rst_error",     error_o, 0);
        check("rst_issue_rdy", cpu_issue_ready_o, 1);
        #2 rst_ni = 1'b1;
        cyc();
    endtask

    // Directed issue/commit vectors, one row per cycle; expectations are
    // the values seen before the clock edge that ends the row.
    typedef struct {
        logic          iv;
        logic [IW-1:0] iid;
        logic [NC-1:0] rdy;
        logic [NC-1:0] acc;
        logic [NC-1:0] wb;
        logic          cv;
        logic [IW-1:0] cid;
        logic          kill;
        logic [NC-1:0] e_cpv;
        logic          e_rdy;
        logic          e_acc;
        logic          e_wb;
        logic [NC-1:0] e_cmt;
        logic          e_busy;
        logic          e_err;
    } vec_t;

    vec_t vecs [11];

    // Reference model state for the random phase.
    logic          m_v    [16];
    int            m_own  [16];
    logic          m_err;
    int            m_ptr;
    logic          m_ov;
    logic [IW-1:0] m_oid;
    logic [DW-1:0] m_odata;
    logic [4:0]    m_ord;
    logic          m_owe;

    initial begin
        logic [IW-1:0] b_ids0 [2];
        logic [IW-1:0] b_ids1 [2];
        logic [IW-1:0] b_order [4];
        int            n0;
        int            n1;
        logic          nv [16];
        logic          blk;
        logic          e_rdy;
        logic          acc_any;
        int            win;
        logic          en;
        int            g;
        int            j;
        int            r;
        logic [IW-1:0] gid;
        logic [IW-1:0] a_id;
        logic [IW-1:0] cmt_id;

        //                iv    iid   rdy    acc    wb     cv    cid   kill  e_cpv  rdy   acc   wb    cmt    busy  err
        vecs[0]  = '{1'b1, 4'd3, 2'b11, 2'b10, 2'b10, 1'b0, 4'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd3, 2'b11, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'd5, 2'b01, 2'b01, 2'b01, 1'b0, 4'd0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'd5, 2'b11, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'd5, 2'b11, 2'b00, 2'b00, 1'b1, 4'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'd5, 2'b11, 2'b01, 2'b00, 1'b1, 4'd5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'd5, 2'b11, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd5, 2'b11, 2'b00, 2'b00, 1'b1, 4'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'd5, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd7, 2'b11, 2'b11, 2'b10, 1'b0, 4'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd7, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};

        clear_inputs();
        do_reset();

        // ---------- table: issue, collision, kill, multi-accept ----------
        for (int v = 0; v < 11; v++) begin
            clear_inputs();
            cpu_issue_valid_i    = vecs[v].iv;
            cpu_issue_id_i       = vecs[v].iid;
            cp_issue_ready_i     = vecs[v].rdy;
            cp_issue_accept_i    = vecs[v].acc;
            cp_issue_writeback_i = vecs[v].wb;
            cpu_commit_valid_i   = vecs[v].cv;
            cpu_commit_id_i      = vecs[v].cid;
            cpu_commit_kill_i    = vecs[v].kill;
            #2;
            check($sformatf("vec%0d_cp_issue_valid", v), cp_issue_valid_o, vecs[v].e_cpv);
            check($sformatf("vec%0d_issue_ready", v),    cpu_issue_ready_o, vecs[v].e_rdy);
            check($sformatf("vec%0d_issue_accept", v),   cpu_issue_accept_o, vecs[v].e_acc);
            check($sformatf("vec%0d_issue_wb", v),       cpu_issue_writeback_o, vecs[v].e_wb);
            check($sformatf("vec%0d_commit_valid", v),   cp_commit_valid_o, vecs[v].e_cmt);
            check($sformatf("vec%0d_busy", v),           busy_o, vecs[v].e_busy);
            check($sformatf("vec%0d_error", v),          error_o, vecs[v].e_err);
            cyc();
        end

        // ---------- A: ID 3 (owner cp1) retires, reissue stalls that cycle ----------
        clear_inputs();
        cpu_issue_valid_i  = 1'b1;
        cpu_issue_id_i     = 4'd3;
        cpu_result_ready_i = 1'b1;
        set_res(1, 4'd3, 32'hA5A5_0003, 5'd7, 1'b1);
        #2;
        check("A1_issue_ready_stall", cpu_issue_ready_o, 0);
        check("A1_cp_issue_valid",    cp_issue_valid_o, 2'b00);
        check("A1_res_ready",         cp_result_ready_o, 2'b10);
        check("A1_out_valid",         cpu_result_valid_o, 0);
        cyc();
        clear_inputs();
        cpu_issue_valid_i  = 1'b1;
        cpu_issue_id_i     = 4'd3;
        cp_issue_accept_i  = 2'b10;
        cpu_result_ready_i = 1'b1;
        set_res(1, 4'd7, 32'h0, 5'd1, 1'b0);
        #2;
        check("A2_out_valid", cpu_result_valid_o, 1);
        check("A2_out_id",    cpu_result_id_o, 3);
        check("A2_out_data",  cpu_result_data_o, 32'hA5A5_0003);
        check("A2_out_rd",    cpu_result_rd_o, 7);
        check("A2_out_we",    cpu_result_we_o, 1);
        check("A2_issue_ready_free", cpu_issue_ready_o, 1);
        check("A2_res_ready", cp_result_ready_o, 2'b10);
        cyc();
        clear_inputs();
        cpu_result_ready_i = 1'b1;
        set_res(0, 4'd7, 32'h0000_7777, 5'd2, 1'b0);
        #2;
        check("A3_nonowner_dropped", cpu_result_valid_o, 0);
        check("A3_res_ready",        cp_result_ready_o, 2'b01);
        check("A3_busy",             busy_o, 1);
        cyc();
        clear_inputs();
        cpu_result_ready_i = 1'b1;
        #2;
        check("A4_out_valid", cpu_result_valid_o, 1);
        check("A4_out_id",    cpu_result_id_o, 7);
        check("A4_out_data",  cpu_result_data_o, 32'h0000_7777);
        check("A4_out_rd",    cpu_result_rd_o, 2);
        cyc();

        // ---------- B: alternating grants at full throughput ----------
        do_reset();
        b_ids0 = '{4'd1, 4'd4};
        b_ids1 = '{4'd2, 4'd6};
        b_order = '{4'd1, 4'd2, 4'd4, 4'd6};
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            cpu_issue_valid_i    = 1'b1;
            cpu_issue_id_i       = (k % 2 == 0) ? b_ids0[k/2] : b_ids1[k/2];
            cp_issue_accept_i    = (k % 2 == 0) ? 2'b01 : 2'b10;
            cp_issue_writeback_i = 2'b11;
            #2;
            check($sformatf("B_issue%0d_ready", k), cpu_issue_ready_o, 1);
            cyc();
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            cpu_result_ready_i = 1'b1;
            if (n0 < 2) set_res(0, b_ids0[n0], 32'hD000_0000 + 32'(b_ids0[n0]), 5'd3, 1'b1);
            if (n1 < 2) set_res(1, b_ids1[n1], 32'hD000_0000 + 32'(b_ids1[n1]), 5'd4, 1'b1);
            #2;
            check($sformatf("B%0d_res_ready", k), cp_result_ready_o,
                  (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            check($sformatf("B%0d_out_valid", k), cpu_result_valid_o, (k > 0));
            if (k > 0) begin
                check($sformatf("B%0d_out_id", k),   cpu_result_id_o, b_order[k-1]);
                check($sformatf("B%0d_out_data", k), cpu_result_data_o, 32'hD000_0000 + 32'(b_order[k-1]));
            end
            if (k % 2 == 0) n0++;
            else            n1++;
            cyc();
        end
        clear_inputs();
        #2;
        check("B_busy_idle", busy_o, 0);
        cyc();

        // ---------- C: CPU back-pressure for 5 cycles, then stray result ----------
        clear_inputs();
        cpu_issue_valid_i  = 1'b1;
        cpu_issue_id_i     = 4'd8;
        cp_issue_accept_i  = 2'b01;
        cpu_result_ready_i = 1'b1;
        #2;
        check("C1_issue_ready", cpu_issue_ready_o, 1);
        cyc();
        clear_inputs();
        set_res(0, 4'd8, 32'hD000_0008, 5'd9, 1'b1);
        #2;
        check("C2_res_ready", cp_result_ready_o, 2'b01);
        check("C2_out_valid", cpu_result_valid_o, 0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            set_res(1, 4'd9, 32'h0, 5'd0, 1'b0);
            #2;
            check($sformatf("C3_%0d_valid", k),     cpu_result_valid_o, 1);
            check($sformatf("C3_%0d_id", k),        cpu_result_id_o, 8);
            check($sformatf("C3_%0d_data", k),      cpu_result_data_o, 32'hD000_0008);
            check($sformatf("C3_%0d_rd", k),        cpu_result_rd_o, 9);
            check($sformatf("C3_%0d_we", k),        cpu_result_we_o, 1);
            check($sformatf("C3_%0d_res_ready", k), cp_result_ready_o, 2'b00);
            check($sformatf("C3_%0d_error", k),     error_o, 0);
            cyc();
        end
        clear_inputs();
        cpu_result_ready_i = 1'b1;
        set_res(1, 4'd9, 32'h0, 5'd0, 1'b0);
        #2;
        check("C4_out_id",    cpu_result_id_o, 8);
        check("C4_res_ready", cp_result_ready_o, 2'b10);
        cyc();
        clear_inputs();
        #2;
        check("C5_stray_dropped", cpu_result_valid_o, 0);
        check("C5_error",         error_o, 1);
        check("C5_busy",          busy_o, 0);
        cyc();

        // ---------- random run against the reference model ----------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i]   = 1'b0;
            m_own[i] = 0;
        end
        m_err = 1'b0;
        m_ptr = 0;
        m_ov  = 1'b0;
        m_oid = '0;
        m_odata = '0;
        m_ord = '0;
        m_owe = 1'b0;
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            cpu_issue_valid_i    = 1'($urandom_range(0, 1));
            cpu_issue_id_i       = 4'($urandom_range(0, 5));
            cp_issue_ready_i     = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r = int'($urandom_range(0, 15));
            cp_issue_accept_i    = (r == 0) ? 2'b11 : (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : 2'b10;
            cp_issue_writeback_i = 2'($urandom_range(0, 3));
            cpu_commit_valid_i   = ($urandom_range(0, 3) == 0);
            cpu_commit_id_i      = 4'($urandom_range(0, 5));
            cpu_commit_kill_i    = 1'($urandom_range(0, 1));
            cpu_result_ready_i   = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NC; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_res(p, 4'($urandom_range(0, 5)), $urandom(), 5'($urandom_range(0, 31)),
                            1'($urandom_range(0, 1)));
                end
            end
            #2;
            a_id   = cpu_issue_id_i;
            cmt_id = cpu_commit_id_i;

            // issue and commit rules
            blk     = m_v[a_id];
            e_rdy   = !blk && (cp_issue_ready_i == 2'b11);
            acc_any = (cp_issue_accept_i != 2'b00);
            win     = cp_issue_accept_i[0] ? 0 : 1;
            check("rnd_cp_issue_valid", cp_issue_valid_o, (cpu_issue_valid_i && !blk) ? 2'b11 : 2'b00);
            check("rnd_issue_ready",    cpu_issue_ready_o, e_rdy);
            check("rnd_issue_accept",   cpu_issue_accept_o, acc_any);
            check("rnd_issue_wb",       cpu_issue_writeback_o, acc_any && cp_issue_writeback_i[win]);
            check("rnd_commit_valid",   cp_commit_valid_o, cpu_commit_valid_i ? 2'b11 : 2'b00);

            // round-robin rule
            en = !m_ov || cpu_result_ready_i;
            g  = -1;
            if (en) begin
                for (int k = 0; k < NC; k++) begin
                    j = (m_ptr + k) % NC;
                    if (g < 0 && cp_result_valid_i[j]) g = j;
                end
            end
            check("rnd_res_ready", cp_result_ready_o, (g >= 0) ? (64'd1 << g) : 64'd0);

            // registered state
            check("rnd_out_valid", cpu_result_valid_o, m_ov);
            if (m_ov) begin
                check("rnd_out_id",   cpu_result_id_o, m_oid);
                check("rnd_out_data", cpu_result_data_o, m_odata);
                check("rnd_out_rd",   cpu_result_rd_o, m_ord);
                check("rnd_out_we",   cpu_result_we_o, m_owe);
            end
            r = 0;
            for (int i = 0; i < 16; i++) if (m_v[i]) r++;
            check("rnd_busy",  busy_o, (r != 0));
            check("rnd_error", error_o, m_err);

            // advance the model by one clock
            nv = m_v;
            if (g >= 0) begin
                gid = cp_result_id_i[g*IW +: IW];
                if (m_v[gid] && m_own[gid] == g) begin
                    nv[gid] = 1'b0;
                    m_ov    = 1'b1;
                    m_oid   = gid;
                    m_odata = cp_result_data_i[g*DW +: DW];
                    m_ord   = cp_result_rd_i[g*5 +: 5];
                    m_owe   = cp_result_we_i[g];
                end else begin
                    m_err = 1'b1;
                    if (cpu_result_ready_i) m_ov = 1'b0;
                end
                m_ptr = (g + 1) % NC;
            end else if (cpu_result_ready_i) begin
                m_ov = 1'b0;
            end
            if (cpu_commit_valid_i && cpu_commit_kill_i && m_v[cmt_id]) nv[cmt_id] = 1'b0;
            if (cpu_issue_valid_i && e_rdy && acc_any) begin
                nv[a_id]    = 1'b1;
                m_own[a_id] = win;
                if (cp_issue_accept_i == 2'b11) m_err = 1'b1;
            end
            m_v = nv;
            cyc();
        end

        // ---------- reset in the middle of a pending result ----------
        clear_inputs();
        cpu_issue_valid_i  = 1'b1;
        cpu_issue_id_i     = 4'd10;
        cp_issue_accept_i  = 2'b01;
        cpu_result_ready_i = 1'b1;
        cyc();
        clear_inputs();
        set_res(0, 4'd10, 32'hCAFE_000A, 5'd5, 1'b1);
        cyc();
        clear_inputs();
        #2;
        check("R_pending_valid", cpu_result_valid_o, 1);
        check("R_pending_id",    cpu_result_id_o, 10);
        rst_ni = 1'b0;
        #1;
        check("R_async_valid", cpu_result_valid_o, 0);
        check("R_async_busy",  busy_o, 0);
        check("R_async_error", error_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xif_coproc_arbiter.md
# xif_coproc_arbiter

- Shares the single CORE-V-XIF port of the CPU subsystem between NUM_COPROC coprocessors.
- Broadcasts issue and commit offers to all coprocessors and records which coprocessor accepted each instruction ID in an owner scoreboard.
- Round-robin arbitrates the coprocessor result channels into one registered CPU result channel.
- Sits between the CPU subsystem's XIF ports and the coprocessor instances in the MCU top.

## Interface
Parameters:
- NUM_COPROC, 2: number of coprocessors, 2..8.
- ID_W, 4: instruction ID width; the scoreboard has 2**ID_W entries.
- DATA_W, 32: result data width.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- cpu_issue_valid_i, in, 1: issue offer from CPU.
- cpu_issue_id_i, in, ID_W: ID of the issue offer.
- cpu_issue_ready_o, out, 1: issue handshake completes.
- cpu_issue_accept_o, out, 1: some coprocessor accepted the offer.
- cpu_issue_writeback_o, out, 1: the winning coprocessor will write rd.
- cp_issue_valid_o, out, NUM_COPROC: per-coprocessor issue offer.
- cp_issue_ready_i, in, NUM_COPROC: per-coprocessor issue ready.
- cp_issue_accept_i, in, NUM_COPROC: per-coprocessor accept.
- cp_issue_writeback_i, in, NUM_COPROC: per-coprocessor writeback flag.
- cpu_commit_valid_i, in, 1: commit strobe from CPU.
- cpu_commit_id_i, in, ID_W: ID being committed.
- cpu_commit_kill_i, in, 1: commit kills the instruction.
- cp_commit_valid_o, out, NUM_COPROC: commit strobe, broadcast.
- cp_result_valid_i, in, NUM_COPROC: per-coprocessor result valid.
- cp_result_ready_o, out, NUM_COPROC: per-coprocessor result ready.
- cp_result_id_i, in, NUM_COPROC*ID_W: result ID, packed with coprocessor i at bits [i*ID_W +: ID_W].
- cp_result_data_i, in, NUM_COPROC*DATA_W: result data, packed the same way.
- cp_result_rd_i, in, NUM_COPROC*5: destination register, packed the same way.
- cp_result_we_i, in, NUM_COPROC: result write enable.
- cpu_result_valid_o, out, 1: registered result valid.
- cpu_result_ready_i, in, 1: CPU takes the result.
- cpu_result_id_o, out, ID_W: registered result ID.
- cpu_result_data_o, out, DATA_W: registered result data.
- cpu_result_rd_o, out, 5: registered destination register.
- cpu_result_we_o, out, 1: registered write enable.
- busy_o, out, 1: at least one scoreboard entry is valid.
- error_o, out, 1: sticky protocol error flag.

## Operation
Scoreboard:
- Each entry holds valid, owner (clog2(NUM_COPROC) bits) and wb.
- Reset clears every entry.

Issue:
- Offer blocked when valid[cpu_issue_id_i] = 1, i.e. an ID collision.
- cp_issue_valid_o = {NUM_COPROC{cpu_issue_valid_i & ~blocked}}. It must not depend on any cp_issue_ready_i.
- cpu_issue_ready_o = ~blocked & (&cp_issue_ready_i).
- cpu_issue_accept_o = |cp_issue_accept_i.
- cpu_issue_writeback_o = writeback flag of the winner.
- Winner: lowest-index accepting coprocessor.
- More than one accept in the same handshake sets error_o; the winner is still the lowest index.
- On an accepted handshake, write the entry for that ID: valid=1, owner=winner, wb=writeback.

Commit:
- cp_commit_valid_o = {NUM_COPROC{cpu_commit_valid_i}}, combinational broadcast.
- A kill on a valid entry clears that entry.
- A non-kill commit does not change the scoreboard.

Result:
- xif_rr_arbiter picks one requester among cp_result_valid_i.
- Grant is issued only when the output register is empty or drains this cycle (cpu_result_ready_i & cpu_result_valid_o).
- cp_result_ready_o is one-hot to the granted coprocessor; the payload is captured on that handshake.
- The round-robin pointer advances to grant+1 after each grant.
- On capture, the scoreboard entry for the result ID is cleared.
- Result whose ID is not valid, or comes from a non-owner: accept and discard, set error_o, leave the scoreboard unchanged, do not load the output register.

## Timing
- Issue and commit paths are combinational, zero latency.
- Result latency: one cycle from the cp handshake to cpu_result_valid_o.
- Result throughput: one result per cycle while the CPU holds ready high.
- cpu_result_*_o stays stable while valid & ~ready.
- An ID cleared by a result in cycle t can be issued again from cycle t+1; an issue of that ID in cycle t stalls.
- Issue of ID X and a kill commit of ID X in the same cycle: the issue is blocked (the entry is still valid in cycle t), the kill clears the entry, and the issue succeeds in cycle t+1.
- Reset values: all registered outputs, busy_o, error_o and the round-robin pointer are 0. Combinational outputs follow their inputs.
- Reset asserted mid-operation drops any in-flight result and clears the scoreboard.

## Structure
- Package xif_arb_pkg holds:
  - sb_entry_t struct {valid, owner, wb}.
  - Function owner_width(NUM_COPROC).
- Sub-module xif_rr_arbiter (parameter N): inputs req, en; outputs gnt one-hot and gnt_idx; owns the round-robin pointer.
- The top module holds the scoreboard, the issue and commit logic, and the output register.

## Test plan
- Issue ID 3 with cp1 accepting and writeback=1 -> cpu_issue_accept_o=1, cpu_issue_writeback_o=1, busy_o=1; entry 3 has owner 1.
- Issue ID 3 again while it is outstanding -> cpu_issue_ready_o=0 and cp_issue_valid_o=0 until cp1 returns its result for ID 3.
- cp0 and cp1 both hold results with CPU ready high -> grants alternate 0,1,0,1; each result appears on cpu_result_*_o one cycle after its cp handshake.
- CPU ready low for 5 cycles with a result pending -> outputs stable for those cycles, and cp_result_ready_o=0 throughout.
- Issue ID 5 to cp0, then commit ID 5 with kill -> entry 5 cleared and busy_o=0.
- Both coprocessors accept the same issue -> error_o=1 (sticky) and owner=0; a result for a non-outstanding ID sets error_o and is dropped.
